sqmux_sel_ctrl: RTL and testbench

// - Parametrised N-source clock-select sequencer for the SQMUX clock-mux tree; runs entirely in the fabric clock domain.
// - Accepts source-switch requests over a valid/ready handshake.
// - Sequences each switch as gate-off, dead time, select change, settle, gate-on.
// - Drives encoded and one-hot selects plus per-source gate enables, so the downstream muxes never switch while a clock is enabled.

---
 rtl/sqmux_sel_ctrl.sv | 157 +++++++++++++++
 tb/tb_sqmux_sel_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// sqmux_sel_ctrl
// Clock-select sequencer for the SQMUX clock-mux tree (fabric clock domain).
// A switch request is accepted over a valid/ready handshake. Each switch runs
// as gate-off, dead time, select change, settle, gate-on, so the downstream
// muxes never change select while any source clock gate is open.
//
// Optional feature macro: SQMUX_SEL_CTRL_ERR_EN
//   defined     -> 'err' port present; an out-of-range request sets a sticky
//                  error flag in its DONE cycle (cleared only by reset)
//   not defined -> no 'err' port; out-of-range requests are silent no-ops
//
// Ports
//   clk         in   1      fabric clock, all state on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   req_valid   in   1      switch request valid
//   req_sel     in   SELW   requested source index (sampled at accept only)
//   req_ready   out  1      controller idle and able to accept a request
//   done        out  1      one-cycle pulse: switch complete / request retired
//   sel         out  SELW   encoded select to the mux tree
//   sel_onehot  out  N_SRC  one-hot of sel
//   gate_en     out  N_SRC  per-source clock gate enable, at most one bit set
//   busy        out  1      switch sequence in progress
//   err         out  1      sticky out-of-range flag (macro builds only)
// ---------------------------------------------------------------------------
module sqmux_sel_ctrl #(
  parameter int N_SRC      = 4,
  parameter int SELW       = $clog2(N_SRC),
  parameter int OFF_CYCLES = 4,
  parameter int SW_CYCLES  = 2,
  parameter int RESET_SEL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [SELW-1:0]  req_sel,
  output logic             req_ready,
  output logic             done,
  output logic [SELW-1:0]  sel,
  output logic [N_SRC-1:0] sel_onehot,
  output logic [N_SRC-1:0] gate_en,
  output logic             busy
`ifdef SQMUX_SEL_CTRL_ERR_EN
  , output logic           err
`endif
);

  localparam int MAX_CYC = (OFF_CYCLES > SW_CYCLES) ? OFF_CYCLES : SW_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]    OFF_LOAD  = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0]    SW_LOAD   = CW'(SW_CYCLES - 1);
  localparam logic [SELW-1:0]  RST_SEL   = SELW'(RESET_SEL);
  localparam logic [N_SRC-1:0] RST_OH    = N_SRC'(1) << RESET_SEL;
  // One extra bit so the range compare also works when N_SRC is a power of 2
  localparam logic [SELW:0]    N_SRC_EXT = (SELW + 1)'(N_SRC);

  typedef enum logic [1:0] {
    IDLE,
    GATE_OFF,
    SWITCH,
    GATE_ON
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] pend_sel;
  logic            accept;
  logic            in_range;

  // Request qualification: a handshake completes only when we advertise
  // ready, and an index past the last source is never acted upon.
  assign accept   = req_valid & req_ready;
  assign in_range = ({1'b0, req_sel} < N_SRC_EXT);

  // Main sequencer. All outputs are registered here so the mux tree sees
  // glitch-free levels. The gates are closed on the same edge that leaves
  // IDLE and the select only moves after the full dead time, which keeps
  // gate_en at zero in every cycle where sel differs from the cycle before.
  // req_ready is also held low during a no-op DONE cycle: otherwise a
  // back-to-back no-op could produce two DONE pulses in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_sel   <= RST_SEL;
      sel        <= RST_SEL;
      sel_onehot <= RST_OH;
      gate_en    <= RST_OH;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef SQMUX_SEL_CTRL_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (in_range && (req_sel != sel)) begin
              state    <= GATE_OFF;
              pend_sel <= req_sel;
              cnt      <= OFF_LOAD;
              gate_en  <= '0;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
`ifdef SQMUX_SEL_CTRL_ERR_EN
              if (!in_range) begin
                err <= 1'b1;
              end
`endif
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        GATE_OFF: begin
          if (cnt == '0) begin
            state      <= SWITCH;
            sel        <= pend_sel;
            sel_onehot <= N_SRC'(1) << pend_sel;
            cnt        <= SW_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        SWITCH: begin
          if (cnt == '0) begin
            state   <= GATE_ON;
            gate_en <= sel_onehot;
            done    <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GATE_ON: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sqmux_sel_ctrl
// Bench for sqmux_sel_ctrl. A 4-source instance is checked every cycle
// against a cycle-count model of the switch timeline; a 3-source instance
// exercises the out-of-range request. Directed sequences add literal
// expectations at key cycles. Build with SQMUX_SEL_CTRL_ERR_EN defined to
// include the err port.
// ---------------------------------------------------------------------------
module tb_sqmux_sel_ctrl;

  localparam int OFF = 4;
  localparam int SW  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic       req_ready, done, busy;
  logic [1:0] sel;
  logic [3:0] sel_onehot, gate_en;

  logic       v3 = 1'b0;
  logic [1:0] s3 = 2'd0;
  logic       ready3, done3, busy3;
  logic [1:0] sel3;
  logic [2:0] onehot3, gate3;

`ifdef SQMUX_SEL_CTRL_ERR_EN
  logic err;
  logic err3;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Free-running fabric clock, 10 time-unit period.
  always #5 clk = ~clk;

  sqmux_sel_ctrl #(
    .N_SRC(4), .OFF_CYCLES(OFF), .SW_CYCLES(SW), .RESET_SEL(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .done       (done),
    .sel        (sel),
    .sel_onehot (sel_onehot),
    .gate_en    (gate_en),
    .busy       (busy)
`ifdef SQMUX_SEL_CTRL_ERR_EN
    , .err      (err)
`endif
  );

  sqmux_sel_ctrl #(
    .N_SRC(3), .OFF_CYCLES(OFF), .SW_CYCLES(SW), .RESET_SEL(0)
  ) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v3),
    .req_sel    (s3),
    .req_ready  (ready3),
    .done       (done3),
    .sel        (sel3),
    .sel_onehot (onehot3),
    .gate_en    (gate3),
    .busy       (busy3)
`ifdef SQMUX_SEL_CTRL_ERR_EN
    , .err      (err3)
`endif
  );

  // Single comparison point: every mismatch is reported and counted here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a request for the 4-source instance one unit after a rising edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s);
    @(posedge clk);
    #1;
    req_valid = v;
    req_sel   = s;
  endtask

  // Timeline model: mode 0 = idle, 1 = switching (age counts cycles since
  // accept), 2 = no-op retire cycle. cur holds the committed source.
  int m_mode, m_age, m_cur, m_tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_age  <= 0;
      m_cur  <= 0;
      m_tgt  <= 0;
    end else if (m_mode == 0) begin
      if (req_valid) begin
        if (int'(req_sel) < 4 && int'(req_sel) != m_cur) begin
          m_mode <= 1;
          m_age  <= 1;
          m_tgt  <= int'(req_sel);
        end else begin
          m_mode <= 2;
        end
      end
    end else if (m_mode == 2) begin
      m_mode <= 0;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == OFF + SW + 2) begin
        m_mode <= 0;
        m_cur  <= m_tgt;
      end
    end
  end

  function automatic int expSel();
    return (m_mode == 1 && m_age >= OFF + 1) ? m_tgt : m_cur;
  endfunction

  function automatic int expGate();
    if (m_mode != 1) return 1 << m_cur;
    return (m_age == OFF + SW + 1) ? (1 << m_tgt) : 0;
  endfunction

  function automatic int expDone();
    return (m_mode == 2 || (m_mode == 1 && m_age == OFF + SW + 1)) ? 1 : 0;
  endfunction

  logic [1:0] prev_sel = 2'd0;
  logic       prev_done = 1'b0;
  logic       prev_rst = 1'b0;

  // Per-cycle comparison against the model plus invariant checks, sampled
  // on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      checkOutput("sel", 32'(sel), 32'(expSel()));
      checkOutput("sel_onehot", 32'(sel_onehot), 32'(1 << expSel()));
      checkOutput("gate_en", 32'(gate_en), 32'(expGate()));
      checkOutput("done", 32'(done), 32'(expDone()));
      checkOutput("req_ready", 32'(req_ready), (m_mode == 0) ? 32'd1 : 32'd0);
      checkOutput("busy", 32'(busy), (m_mode == 1) ? 32'd1 : 32'd0);
      checkOutput("gate_popcount_le1", ($countones(gate_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (prev_rst && prev_done) begin
        checkOutput("done_not_consecutive", 32'(done), 32'd0);
      end
      if (prev_rst && sel != prev_sel) begin
        checkOutput("gate_off_on_sel_change", 32'(gate_en), 32'd0);
      end
`ifdef SQMUX_SEL_CTRL_ERR_EN
      checkOutput("err", 32'(err), 32'd0);
`endif
    end
    prev_sel  <= sel;
    prev_done <= done;
    prev_rst  <= rst_n;
  end

  initial begin
    // Reset defaults
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_gate_en", 32'(gate_en), 32'h1);
    checkOutput("rst_sel", 32'(sel), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    chk_on = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Request equal to the current select: retire only
    applyStimulus(1'b1, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_valid = 1'b0;
      #1;
      if (k == 1) begin
        checkOutput("eq_done_t1", 32'(done), 32'h1);
        checkOutput("eq_gate_t1", 32'(gate_en), 32'h1);
        checkOutput("eq_busy_t1", 32'(busy), 32'h0);
      end
      if (k == 2) checkOutput("eq_done_t2", 32'(done), 32'h0);
      if (k == 3) checkOutput("eq_ready_t3", 32'(req_ready), 32'h1);
    end

    // Full switch 0 -> 2
    applyStimulus(1'b1, 2'd2);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_valid = 1'b0;
      #1;
      checkOutput("sw02_gate", 32'(gate_en), (k <= 6) ? 32'h0 : 32'h4);
      checkOutput("sw02_sel", 32'(sel), (k >= 5) ? 32'h2 : 32'h0);
      checkOutput("sw02_done", 32'(done), (k == 7) ? 32'h1 : 32'h0);
      checkOutput("sw02_ready", 32'(req_ready), (k == 8) ? 32'h1 : 32'h0);
    end

    // 2 -> 3, with a held request for 1 arriving while busy
    applyStimulus(1'b1, 2'd3);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_sel = 2'd1;
      if (k == 9) req_valid = 1'b0;
      #1;
      if (k == 7) begin
        checkOutput("hold_done_t7", 32'(done), 32'h1);
        checkOutput("hold_sel_t7", 32'(sel), 32'h3);
        checkOutput("hold_gate_t7", 32'(gate_en), 32'h8);
      end
      if (k == 8) begin
        checkOutput("hold_ready_t8", 32'(req_ready), 32'h1);
        checkOutput("hold_busy_t8", 32'(busy), 32'h0);
      end
      if (k == 9) checkOutput("hold_busy_t9", 32'(busy), 32'h1);
      if (k == 12) checkOutput("hold_sel_t12", 32'(sel), 32'h3);
      if (k == 13) checkOutput("hold_sel_t13", 32'(sel), 32'h1);
      if (k == 15) begin
        checkOutput("hold_done_t15", 32'(done), 32'h1);
        checkOutput("hold_gate_t15", 32'(gate_en), 32'h2);
      end
      if (k == 16) checkOutput("hold_ready_t16", 32'(req_ready), 32'h1);
    end

    // Reset in the middle of a 0 -> 2 switch
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 2'd2);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_valid = 1'b0;
      if (k == 5) rst_n = 1'b0;
      #1;
      if (k == 4) checkOutput("mid_gate_t4", 32'(gate_en), 32'h0);
    end
    checkOutput("mid_rst_gate", 32'(gate_en), 32'h1);
    checkOutput("mid_rst_sel", 32'(sel), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #2 checkOutput("mid_rst_no_done", 32'(done), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2 checkOutput("post_rst_no_done", 32'(done), 32'h0);
    end

    // Out-of-range request on the 3-source instance
`ifdef SQMUX_SEL_CTRL_ERR_EN
    checkOutput("n3_err_pre", 32'(err3), 32'h0);
`endif
    @(posedge clk);
    #1;
    v3 = 1'b1;
    s3 = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) v3 = 1'b0;
      #1;
      checkOutput("n3_done", 32'(done3), (k == 1) ? 32'h1 : 32'h0);
      checkOutput("n3_sel", 32'(sel3), 32'h0);
      checkOutput("n3_gate", 32'(gate3), 32'h1);
      checkOutput("n3_busy", 32'(busy3), 32'h0);
`ifdef SQMUX_SEL_CTRL_ERR_EN
      checkOutput("n3_err", 32'(err3), 32'h1);
`endif
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
